execute_unit: RTL and testbench

//  Execute stage directly upstream of the 16x32 register file write port.

---
 rtl/execute_unit.sv | 197 +++++++++++++++++++
 tb/tb_execute_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/execute_unit.sv
// Execute stage feeding the register file write port: single-cycle ALU ops
// plus an iterative shift-add multiply, finished by a one-cycle write strobe.
module execute_unit #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              Start,
    input  logic [3:0]        Opcode,
    input  logic [WIDTH-1:0]  Read1,
    input  logic [WIDTH-1:0]  Read2,
    input  logic [ADDR_W-1:0] Daddr,
    output logic              Busy,
    output logic              Done,
    output logic              RegWr,
    output logic [ADDR_W-1:0] Waddr,
    output logic [WIDTH-1:0]  Writedata,
    output logic              Overflow,
    output logic              IllegalOp
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    localparam int                CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

    logic [1:0]        state_q,  state_d;
    logic [ADDR_W-1:0] daddr_q,  daddr_d;
    logic [WIDTH-1:0]  mcand_q,  mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [WIDTH-1:0]  acc_q,    acc_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic              regwr_q,  regwr_d;
    logic [ADDR_W-1:0] waddr_q,  waddr_d;
    logic [WIDTH-1:0]  wdata_q,  wdata_d;
    logic              ovf_q,    ovf_d;
    logic              ill_q,    ill_d;

    logic [WIDTH-1:0]  alu_res_s;
    logic              alu_ovf_s;
    logic              alu_ill_s;
    logic [WIDTH-1:0]  sum_s;
    logic [WIDTH-1:0]  diff_s;
    logic [WIDTH-1:0]  acc_step_s;

    // Only physically present registers may be written.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < NUM_REGS_W);
    endfunction

    assign sum_s      = Read1 + Read2;
    assign diff_s     = Read1 - Read2;
    assign acc_step_s = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Single-cycle ALU result and flags from the operands being accepted
    always_comb begin
        alu_res_s = '0;
        alu_ovf_s = 1'b0;
        alu_ill_s = 1'b0;
        case (Opcode)
            OP_ADD: begin
                alu_res_s = sum_s;
                alu_ovf_s = (Read1[WIDTH-1] == Read2[WIDTH-1]) && (sum_s[WIDTH-1] != Read1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_s = diff_s;
                alu_ovf_s = (Read1[WIDTH-1] != Read2[WIDTH-1]) && (diff_s[WIDTH-1] != Read1[WIDTH-1]);
            end
            OP_AND:  alu_res_s = Read1 & Read2;
            OP_OR:   alu_res_s = Read1 | Read2;
            OP_XOR:  alu_res_s = Read1 ^ Read2;
            OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(Read1) < $signed(Read2))};
            OP_SLL:  alu_res_s = Read1 << Read2[4:0];
            OP_SRL:  alu_res_s = Read1 >> Read2[4:0];
            default: alu_ill_s = 1'b1;
        endcase
    end

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d  = state_q;
        daddr_d  = daddr_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        regwr_d  = 1'b0;
        waddr_d  = '0;
        wdata_d  = '0;
        ovf_d    = 1'b0;
        ill_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    daddr_d = Daddr;
                    busy_d  = 1'b1;
                    if (Opcode == OP_MUL) begin
                        state_d  = ST_MUL;
                        cnt_d    = '0;
                        acc_d    = '0;
                        mcand_d  = Read1;
                        mplier_d = Read2;
                    end else begin
                        state_d = ST_WB;
                        done_d  = 1'b1;
                        regwr_d = !alu_ill_s && addr_ok(Daddr);
                        waddr_d = Daddr;
                        wdata_d = alu_res_s;
                        ovf_d   = alu_ovf_s;
                        ill_d   = alu_ill_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                busy_d   = 1'b1;
                acc_d    = acc_step_s;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_WB;
                    done_d  = 1'b1;
                    regwr_d = addr_ok(daddr_q);
                    waddr_d = daddr_q;
                    wdata_d = acc_step_s;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            daddr_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            regwr_q  <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            daddr_q  <= daddr_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            regwr_q  <= regwr_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign RegWr     = regwr_q;
    assign Waddr     = waddr_q;
    assign Writedata = wdata_q;
    assign Overflow  = ovf_q;
    assign IllegalOp = ill_q;

endmodule

// File: tb/tb_execute_unit.sv
// Directed and random checks of execute_unit against a behavioural model,
// with expected writes queued at issue and compared when Done pulses.
module tb_execute_unit;

    logic        CLK;
    logic        RESET;
    logic        Start;
    logic [3:0]  Opcode;
    logic [31:0] Read1;
    logic [31:0] Read2;
    logic [4:0]  Daddr;
    logic        Busy;
    logic        Done;
    logic        RegWr;
    logic [4:0]  Waddr;
    logic [31:0] Writedata;
    logic        Overflow;
    logic        IllegalOp;

    typedef struct packed {
        logic        regwr;
        logic [4:0]  waddr;
        logic [31:0] data;
        logic        ovf;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] rf [16];
    int          n_assert = 0;
    int          n_fail   = 0;

    execute_unit dut (
        .CLK(CLK), .RESET(RESET), .Start(Start), .Opcode(Opcode),
        .Read1(Read1), .Read2(Read2), .Daddr(Daddr), .Busy(Busy),
        .Done(Done), .RegWr(RegWr), .Waddr(Waddr), .Writedata(Writedata),
        .Overflow(Overflow), .IllegalOp(IllegalOp)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register file sink: commits on the edge after the strobe
    always @(posedge CLK) begin
        if (RegWr === 1'b1 && Waddr < 5'd16) rf[Waddr[3:0]] <= Writedata;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] addr);
        exp_t        m;
        logic [32:0] w;
        logic [63:0] p;
        m.waddr = addr; m.data = 32'd0; m.ovf = 1'b0; m.ill = 1'b0;
        case (op)
            4'd0: begin w = {a[31], a} + {b[31], b}; m.data = w[31:0]; m.ovf = w[32] ^ w[31]; end
            4'd1: begin w = {a[31], a} - {b[31], b}; m.data = w[31:0]; m.ovf = w[32] ^ w[31]; end
            4'd2: m.data = a & b;
            4'd3: m.data = a | b;
            4'd4: m.data = a ^ b;
            4'd5: m.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: m.data = a << b[4:0];
            4'd7: m.data = a >> b[4:0];
            4'd8: begin p = {32'd0, a} * {32'd0, b}; m.data = p[31:0]; end
            default: m.ill = 1'b1;
        endcase
        m.regwr = !m.ill && (addr < 5'd16);
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_regwr"}, 32'(RegWr), 32'(e.regwr));
            chk({tag, "_waddr"}, 32'(Waddr), 32'(e.waddr));
            chk({tag, "_data"}, Writedata, e.data);
            chk({tag, "_ovf"}, 32'(Overflow), 32'(e.ovf));
            chk({tag, "_ill"}, 32'(IllegalOp), 32'(e.ill));
        end
    endtask

    // Drive one request for a single cycle; optionally queue its expected write
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] addr, input bit push);
        Opcode = op; Read1 = a; Read2 = b; Daddr = addr; Start = 1'b1;
        if (push) sb.push_back(model(op, a, b, addr));
        @(posedge CLK); #1;
        Start = 1'b0;
    endtask

    // Wait (bounded) for Done, counting busy cycles; optionally poke Start while busy
    task automatic expect_done(input string tag, input int max, input bit poke,
                               output int busy_cycles);
        int n = 0;
        busy_cycles = 0;
        while (Done !== 1'b1 && n < max) begin
            if (Busy === 1'b1) busy_cycles++;
            Start = poke && (n == 5 || n == 20);
            Opcode = 4'd0; Read1 = 32'd1; Read2 = 32'd1; Daddr = 5'd1;
            @(posedge CLK); #1;
            n++;
        end
        Start = 1'b0;
        if (Busy === 1'b1) busy_cycles++;
        chk({tag, "_done"}, 32'(Done), 32'd1);
        if (Done === 1'b1) pop_check(tag);
        @(posedge CLK); #1;
        chk({tag, "_done_pulse"}, 32'(Done), 32'd0);
        chk({tag, "_busy_clear"}, 32'(Busy), 32'd0);
    endtask

    initial begin
        int bc;
        int stray;
        RESET = 1'b1; Start = 1'b0; Opcode = 4'd0; Read1 = 32'd0; Read2 = 32'd0; Daddr = 5'd0;
        for (int i = 0; i < 16; i++) rf[i] = 32'd0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_regwr", 32'(RegWr), 32'd0);
        chk("rst_waddr", 32'(Waddr), 32'd0);
        chk("rst_wdata", Writedata, 32'd0);
        chk("rst_ovf", 32'(Overflow), 32'd0);
        chk("rst_ill", 32'(IllegalOp), 32'd0);
        RESET = 1'b0;
        @(posedge CLK); #1;

        issue(4'd0, 32'd5, 32'd7, 5'd2, 1'b1);
        expect_done("add", 4, 1'b0, bc);
        chk("add_latency", 32'(bc), 32'd1);
        chk("add_rf", rf[2], 32'd12);

        issue(4'd1, 32'h8000_0000, 32'd1, 5'd4, 1'b1);
        expect_done("sub_ovf", 4, 1'b0, bc);
        issue(4'd5, 32'd3, 32'hFFFF_FFFF, 5'd5, 1'b1);
        expect_done("slt", 4, 1'b0, bc);
        issue(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd6, 1'b1);
        expect_done("add_ovf", 4, 1'b0, bc);
        issue(4'd6, 32'h0000_00F1, 32'd31, 5'd7, 1'b1);
        expect_done("sll", 4, 1'b0, bc);
        issue(4'd7, 32'h8000_0000, 32'd31, 5'd8, 1'b1);
        expect_done("srl", 4, 1'b0, bc);

        issue(4'd8, 32'h0001_0000, 32'h0001_0003, 5'd9, 1'b1);
        expect_done("mul", 40, 1'b1, bc);
        chk("mul_busy_cycles", 32'(bc), 32'd33);
        stray = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (Done === 1'b1) stray++;
        end
        chk("mul_no_extra_done", 32'(stray), 32'd0);
        chk("mul_rf", rf[9], 32'h0003_0000);

        issue(4'd0, 32'd1, 32'd2, 5'd20, 1'b1);
        expect_done("addr_oob", 4, 1'b0, bc);
        issue(4'hF, 32'd9, 32'd9, 5'd3, 1'b1);
        expect_done("illegal", 4, 1'b0, bc);

        issue(4'd8, 32'd123, 32'd456, 5'd10, 1'b0);
        repeat (9) @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        chk("abort_busy", 32'(Busy), 32'd0);
        stray = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (Done === 1'b1 || RegWr === 1'b1) stray++;
        end
        chk("abort_no_write", 32'(stray), 32'd0);
        issue(4'd0, 32'd100, 32'd23, 5'd11, 1'b1);
        expect_done("post_abort_add", 4, 1'b0, bc);

        // Start held high: a single-cycle op is accepted every other cycle
        for (int k = 0; k < 40; k++) begin
            Opcode = 4'($urandom_range(7, 0));
            Read1 = $urandom; Read2 = $urandom;
            Daddr = 5'($urandom_range(31, 0));
            Start = 1'b1;
            sb.push_back(model(Opcode, Read1, Read2, Daddr));
            @(posedge CLK); #1;
            chk("rnd_done", 32'(Done), 32'd1);
            if (Done === 1'b1) pop_check("rnd");
            Opcode = 4'($urandom_range(15, 0));
            Read1 = $urandom; Read2 = $urandom; Daddr = 5'($urandom_range(31, 0));
            @(posedge CLK); #1;
            chk("rnd_gap", 32'(Done), 32'd0);
        end
        Start = 1'b0;
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
